fpga_private_ram_req_adapter: RTL and testbench

//  Upstream front-end for the FPGA block-RAM replacement of the L2 private banks.

---
 rtl/fpga_private_ram_req_adapter.sv | 118 +++++++++++
 tb/tb_fpga_private_ram_req_adapter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fpga_private_ram_req_adapter.sv
// Request/response front-end for the single-port block RAM that replaces the
// L2 private banks. Requests are turned into RAM strobes when accepted. Read
// data returns one cycle later and either falls straight through to the
// response port or is parked in a small in-order response FIFO.
//
// Handshake: on both channels a transfer happens on a rising clk edge where
// valid and ready are both 1. A source holds valid and its payload stable
// until that edge. req_ready_o is a pure credit signal: it does not depend on
// req_valid_i or rsp_ready_i.
module fpga_private_ram_req_adapter #(
  parameter int ADDR_WIDTH = 12,
  parameter int RESP_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [3:0]            req_be_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_we_o,
  output logic [31:0]           rsp_rdata_o,
  output logic                  mem_csn_o,
  output logic                  mem_wen_o,
  output logic [3:0]            mem_be_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i
);

  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  logic                  inflight_q;
  logic                  we_q;
  logic [CNT_W-1:0]      count_q;
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic                  fifo_we   [RESP_DEPTH];
  logic [31:0]           fifo_rdata[RESP_DEPTH];

  logic [CNT_W:0]        occ;
  logic                  accept;
  logic                  fifo_empty;
  logic [31:0]           live_rdata;
  logic                  fifo_push;
  logic                  fifo_pop;

  // Pointers wrap at RESP_DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit, RAM strobes and response selection.
  always_comb begin
    occ         = {1'b0, count_q} + (CNT_W + 1)'(inflight_q);
    req_ready_o = !rst_i && (occ < (CNT_W + 1)'(RESP_DEPTH));
    accept      = req_valid_i && req_ready_o;

    mem_csn_o   = !accept;
    mem_wen_o   = accept ? !req_we_i : 1'b1;
    mem_be_o    = (accept && req_we_i) ? req_be_i : 4'h0;
    mem_addr_o  = req_addr_i;
    mem_wdata_o = req_wdata_i;

    // Write acks carry zero data regardless of what the RAM drives.
    live_rdata  = we_q ? 32'h0 : mem_rdata_i;
    fifo_empty  = (count_q == '0);

    rsp_valid_o = !rst_i && (!fifo_empty || inflight_q);
    rsp_we_o    = fifo_empty ? we_q : fifo_we[rd_ptr_q];
    rsp_rdata_o = fifo_empty ? live_rdata : fifo_rdata[rd_ptr_q];

    // The live response bypasses the FIFO only when nothing older is queued
    // and the consumer takes it this cycle.
    fifo_push   = inflight_q && !(fifo_empty && rsp_ready_i);
    fifo_pop    = !fifo_empty && rsp_valid_o && rsp_ready_i;
  end

  // Control state: in-flight flag, pointers and occupancy count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight_q <= 1'b0;
      we_q       <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      inflight_q <= accept;
      if (accept) begin
        we_q <= req_we_i;
      end
      if (fifo_push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (fifo_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({fifo_push, fifo_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Response storage; contents are only meaningful under count_q.
  always_ff @(posedge clk_i) begin
    if (!rst_i && fifo_push) begin
      fifo_we[wr_ptr_q]    <= we_q;
      fifo_rdata[wr_ptr_q] <= live_rdata;
    end
  end

endmodule

// File: tb/tb_fpga_private_ram_req_adapter.sv
// Bench for fpga_private_ram_req_adapter: directed scenarios followed by
// random traffic, all checked against a transaction-level model holding the
// expected RAM contents and an ordered queue of outstanding responses.
module tb_fpga_private_ram_req_adapter;

  localparam int AW    = 12;
  localparam int DEPTH = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic          req_we_i = 1'b0;
  logic [3:0]    req_be_i = 4'h0;
  logic [AW-1:0] req_addr_i = '0;
  logic [31:0]   req_wdata_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic          rsp_we_o;
  logic [31:0]   rsp_rdata_o;
  logic          mem_csn_o;
  logic          mem_wen_o;
  logic [3:0]    mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [31:0]   mem_rdata_i = '0;

  fpga_private_ram_req_adapter #(.ADDR_WIDTH(AW), .RESP_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_be_i(req_be_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_we_o(rsp_we_o),
    .rsp_rdata_o(rsp_rdata_o), .mem_csn_o(mem_csn_o), .mem_wen_o(mem_wen_o),
    .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  // ---------------- RAM environment ----------------
  logic [31:0] ram [1 << AW];
  always @(posedge clk) begin
    if (!mem_csn_o) begin
      if (!mem_wen_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) ram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        mem_rdata_i <= $urandom();  // garbage after a write; acks must show 0
      end else begin
        mem_rdata_i <= ram[mem_addr_o];
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask

  logic [32:0] exp_q[$];       // {we, rdata} of accepted, unconsumed requests
  logic [31:0] ref_mem [1 << AW];

  logic        obs_ready, obs_valid, obs_we, last_acc;
  logic [31:0] obs_rdata;

  // Outstanding responses can never exceed the FIFO: check every push.
  always @(posedge clk) begin
    if (!rst_i && dut.fifo_push)
      chk("no_overflow", 32'(dut.count_q < DEPTH), 32'd1);
  end

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle(input logic rst, input logic v, input logic we,
                       input logic [3:0] be, input logic [AW-1:0] addr,
                       input logic [31:0] wd, input logic rr);
    logic exp_ready, acc;
    @(negedge clk);
    rst_i = rst; req_valid_i = v; req_we_i = we; req_be_i = be;
    req_addr_i = addr; req_wdata_i = wd; rsp_ready_i = rr;
    #1;
    obs_ready = req_ready_o; obs_valid = rsp_valid_o;
    obs_we = rsp_we_o; obs_rdata = rsp_rdata_o;
    if (rst) begin
      chk("rst_req_ready", 32'(req_ready_o), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      chk("rst_mem_csn",   32'(mem_csn_o),   32'd1);
      chk("rst_mem_wen",   32'(mem_wen_o),   32'd1);
      chk("rst_mem_be",    32'(mem_be_o),    32'd0);
      exp_q.delete();
      last_acc = 1'b0;
    end else begin
      exp_ready = (exp_q.size() < DEPTH);
      chk("req_ready", 32'(req_ready_o), 32'(exp_ready));
      chk("rsp_valid", 32'(rsp_valid_o), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        chk("rsp_we",    32'(rsp_we_o), 32'(exp_q[0][32]));
        chk("rsp_rdata", rsp_rdata_o,   exp_q[0][31:0]);
      end
      acc = v && exp_ready;
      last_acc = acc;
      chk("mem_csn", 32'(mem_csn_o), 32'(!acc));
      chk("mem_wen", 32'(mem_wen_o), 32'(!(acc && we)));
      chk("mem_be",  32'(mem_be_o),  (acc && we) ? 32'(be) : 32'd0);
      if (acc) begin
        chk("mem_addr",  32'(mem_addr_o), 32'(addr));
        chk("mem_wdata", mem_wdata_o, wd);
      end
      if (exp_q.size() > 0 && rr) void'(exp_q.pop_front());
      if (acc) begin
        if (we) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[addr][8*b +: 8] = wd[8*b +: 8];
          exp_q.push_back({1'b1, 32'h0});
        end else begin
          exp_q.push_back({1'b0, ref_mem[addr]});
        end
      end
    end
  endtask

  task automatic idle(input logic rr);
    cycle(1'b0, 1'b0, 1'b0, 4'h0, '0, 32'h0, rr);
  endtask

  // ---------------- stimulus ----------------
  int k, n_acc;

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end

    // 1. reset held with a request pending
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 4'h0, 12'h010, 32'h0, 1'b1);

    // 2. full write then read-back, responses at latency 1
    cycle(1'b0, 1'b1, 1'b1, 4'hF, 12'h010, 32'hDEADBEEF, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 4'h0, 12'h010, 32'h0, 1'b1);
    chk("t2_ack_valid", 32'(obs_valid), 32'd1);
    chk("t2_ack_we",    32'(obs_we),    32'd1);
    chk("t2_ack_rdata", obs_rdata,      32'h0);
    idle(1'b1);
    chk("t2_rd_we",    32'(obs_we), 32'd0);
    chk("t2_rd_rdata", obs_rdata,   32'hDEADBEEF);

    // 3. partial byte write merges with existing word
    cycle(1'b0, 1'b1, 1'b1, 4'hF,    12'h020, 32'h11223344, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 4'b0010, 12'h020, 32'h0000AB00, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 4'h0,    12'h020, 32'h0, 1'b1);
    idle(1'b1);
    chk("t3_merge", obs_rdata, 32'h1122AB44);
    idle(1'b1);

    // 4. back-pressure: only DEPTH reads accepted until responses drain
    for (int i = 0; i < 4; i++) begin
      ram[i] = 32'hA000_0000 + i; ref_mem[i] = 32'hA000_0000 + i;
    end
    k = 0; n_acc = 0;
    for (int c = 0; c < 4; c++) begin
      cycle(1'b0, 1'b1, 1'b0, 4'h0, AW'(k), 32'h0, 1'b0);
      if (c == 2) chk("t4_ready_low", 32'(obs_ready), 32'd0);
      if (last_acc) begin k++; n_acc++; end
    end
    chk("t4_accepts", 32'(n_acc), 32'd2);
    idle(1'b1);
    chk("t4_first_rsp", obs_rdata, 32'hA000_0000);
    for (int c = 0; c < 20 && k < 4; c++) begin
      cycle(1'b0, 1'b1, 1'b0, 4'h0, AW'(k), 32'h0, 1'b1);
      if (last_acc) k++;
    end
    chk("t4_drain_done", 32'(k), 32'd4);
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) idle(1'b1);
    chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // 5. streaming: 16 back-to-back reads
    n_acc = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 4'h0, AW'(i), 32'h0, 1'b1);
      if (last_acc) n_acc++;
    end
    chk("t5_accepts", 32'(n_acc), 32'd16);
    idle(1'b1);

    // 6. reset with two responses queued discards them
    cycle(1'b0, 1'b1, 1'b0, 4'h0, 12'h001, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 4'h0, 12'h002, 32'h0, 1'b0);
    idle(1'b0);
    chk("t6_queued", 32'(obs_valid), 32'd1);
    cycle(1'b1, 1'b0, 1'b0, 4'h0, '0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 4'h0, '0, 32'h0, 1'b0);
    idle(1'b1);
    chk("t6_rsp_valid", 32'(obs_valid), 32'd0);
    chk("t6_req_ready", 32'(obs_ready), 32'd1);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // 7. random mixed traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      cycle(1'b0, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 4),
            4'($urandom_range(0, 15)), AW'($urandom_range(0, 15)), $urandom(),
            ($urandom_range(0, 9) < 6));
    end
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) idle(1'b1);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
